// File: rtl/julia_csr_pkg.sv
// Shared definitions for the Julia engine CSR/launcher block:
// register map, CTRL/STATUS bit positions and launcher FSM states.
package julia_csr_pkg;

   localparam int REG_CTRL         = 0;
   localparam int REG_STATUS       = 1;
   localparam int REG_A            = 2;
   localparam int REG_B            = 3;
   localparam int REG_BASE_ADDR    = 4;
   localparam int REG_PIXEL_COUNT  = 5;
   localparam int REG_FRAME_PIXELS = 6;
   localparam int REG_CYCLE_COUNT  = 7;

   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

   localparam int FRAME_PIXELS_DEF = 307200;

   typedef enum logic [1:0] {IDLE, ENG_RST, LAUNCH, RUN} state_t;

endpackage

// File: rtl/julia_wr_counter.sv
// Accepted-write counter: clears at frame launch, counts accepted master
// writes and strobes o_hit on the write that reaches the programmed limit.
module julia_wr_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_inc,
   input  logic [W-1:0] i_limit,
   output logic [W-1:0] o_count,
   output logic         o_hit
);

   logic [W-1:0] r_count;
   logic [W-1:0] w_next;

   assign w_next  = r_count + W'(1);
   assign o_hit   = i_inc && (w_next == i_limit);
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= w_next;
      end
   end

endmodule

// File: rtl/julia_csr_launcher.sv
// Avalon-MM CSR slave and launch/monitor FSM for one Julia engine; forwards
// engine pixel writes to the master port with a base-address offset.
module julia_csr_launcher #(
   parameter int MASTER_ADDRESSWIDTH = 32,
   parameter int SLAVE_ADDRESSWIDTH  = 3,
   parameter int DATAWIDTH           = 32,
   parameter int CWIDTH              = 22,
   parameter int FRAME_PIXELS_DEF    = julia_csr_pkg::FRAME_PIXELS_DEF,
   parameter int RST_CYCLES          = 4
) (
   input  logic                           clk,
   input  logic                           toplevel_reset,
   input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
   input  logic [DATAWIDTH-1:0]           slave_writedata,
   input  logic                           slave_write,
   input  logic                           slave_read,
   input  logic                           slave_chipselect,
   output logic [DATAWIDTH-1:0]           slave_readdata,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic [DATAWIDTH-1:0]           master_writedata,
   output logic                           master_write,
   input  logic                           master_waitrequest,
   output logic                           eng_rst_n,
   output logic                           eng_start,
   output logic [CWIDTH-1:0]              eng_a,
   output logic [CWIDTH-1:0]              eng_b,
   input  logic [MASTER_ADDRESSWIDTH-1:0] eng_wr_addr,
   input  logic [DATAWIDTH-1:0]           eng_wr_data,
   input  logic                           eng_wr_enable,
   output logic                           eng_wait_request,
   output logic                           irq
);
   import julia_csr_pkg::*;

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL   = SLAVE_ADDRESSWIDTH'(REG_CTRL);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS = SLAVE_ADDRESSWIDTH'(REG_STATUS);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_A      = SLAVE_ADDRESSWIDTH'(REG_A);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_B      = SLAVE_ADDRESSWIDTH'(REG_B);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_BASE   = SLAVE_ADDRESSWIDTH'(REG_BASE_ADDR);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_PIXCNT = SLAVE_ADDRESSWIDTH'(REG_PIXEL_COUNT);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_FRAME  = SLAVE_ADDRESSWIDTH'(REG_FRAME_PIXELS);
   localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CYCCNT = SLAVE_ADDRESSWIDTH'(REG_CYCLE_COUNT);

   state_t                 r_state;
   logic [RCW-1:0]         r_rst_cnt;
   logic                   r_eng_rst_n, r_eng_start, r_irq;
   logic                   r_done, r_err, r_irq_en;
   logic [DATAWIDTH-1:0]   r_a, r_b, r_base, r_frame_pixels, r_cycle_count, r_readdata;

   logic                   w_wr, w_rd, w_ctrl_wr, w_stat_wr, w_start_req, w_abort;
   logic                   w_idle, w_launch, w_zero_done, w_err_set, w_accept, w_hit;
   logic                   w_clear, w_done_nxt, w_err_nxt, w_irq_en_nxt;
   logic [DATAWIDTH-1:0]   w_pixel_count, w_status, w_ctrl;

   assign w_wr        = slave_chipselect & slave_write;
   assign w_rd        = slave_chipselect & slave_read & ~slave_write;
   assign w_ctrl_wr   = w_wr && (slave_address == A_CTRL);
   assign w_stat_wr   = w_wr && (slave_address == A_STATUS);
   assign w_start_req = w_ctrl_wr & slave_writedata[CTRL_START];
   assign w_abort     = w_ctrl_wr & slave_writedata[CTRL_ABORT];
   assign w_idle      = (r_state == IDLE);

   // Abort beats start; a zero-length frame completes without touching the engine.
   assign w_launch    = w_start_req & ~w_abort & w_idle & (r_frame_pixels != '0);
   assign w_zero_done = w_start_req & ~w_abort & w_idle & (r_frame_pixels == '0);
   assign w_err_set   = w_start_req & (w_abort | ~w_idle);
   assign w_clear     = w_launch | w_zero_done;

   assign master_write     = eng_wr_enable & (r_state == RUN);
   assign master_address   = MASTER_ADDRESSWIDTH'(r_base) + eng_wr_addr;
   assign master_writedata = eng_wr_data;
   assign eng_wait_request = master_waitrequest | (r_state != RUN);
   assign w_accept         = master_write & ~master_waitrequest & ~w_abort;

   // Hardware set wins over a same-cycle W1C.
   assign w_done_nxt   = w_zero_done | w_hit |
                         (r_done & ~(w_stat_wr & slave_writedata[ST_DONE]));
   assign w_err_nxt    = w_err_set |
                         (r_err & ~(w_stat_wr & slave_writedata[ST_ERR]));
   assign w_irq_en_nxt = w_ctrl_wr ? slave_writedata[CTRL_IRQ_EN] : r_irq_en;

   julia_wr_counter #(.W(DATAWIDTH)) u_wr_counter (
      .clk     (clk),
      .rst_n   (toplevel_reset),
      .i_clear (w_clear),
      .i_inc   (w_accept),
      .i_limit (r_frame_pixels),
      .o_count (w_pixel_count),
      .o_hit   (w_hit)
   );

   always_ff @(posedge clk or negedge toplevel_reset) begin
      if (!toplevel_reset) begin
         r_state       <= IDLE;
         r_rst_cnt     <= '0;
         r_eng_rst_n   <= 1'b0;
         r_eng_start   <= 1'b0;
         r_irq         <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_cycle_count <= '0;
      end else begin
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         r_irq       <= w_done_nxt & w_irq_en_nxt;
         r_eng_start <= 1'b0;
         if (w_clear) begin
            r_cycle_count <= '0;
         end else if ((r_state == RUN) && !w_abort && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + DATAWIDTH'(1);
         end
         if (w_abort) begin
            r_state     <= IDLE;
            r_eng_rst_n <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_eng_rst_n <= 1'b1;
                  if (w_launch) begin
                     r_state     <= ENG_RST;
                     r_eng_rst_n <= 1'b0;
                     r_rst_cnt   <= RCW'(RST_CYCLES - 1);
                  end
               end
               ENG_RST: begin
                  if (r_rst_cnt == '0) begin
                     r_state     <= LAUNCH;
                     r_eng_rst_n <= 1'b1;
                     r_eng_start <= 1'b1;
                  end else begin
                     r_rst_cnt <= r_rst_cnt - RCW'(1);
                  end
               end
               LAUNCH:  r_state <= RUN;
               RUN:     if (w_hit) r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge toplevel_reset) begin
      if (!toplevel_reset) begin
         r_irq_en       <= 1'b0;
         r_a            <= '0;
         r_b            <= '0;
         r_base         <= '0;
         r_frame_pixels <= DATAWIDTH'(FRAME_PIXELS_DEF);
      end else begin
         r_irq_en <= w_irq_en_nxt;
         if (w_wr) begin
            case (slave_address)
               A_A:     r_a            <= slave_writedata;
               A_B:     r_b            <= slave_writedata;
               A_BASE:  r_base         <= slave_writedata;
               A_FRAME: r_frame_pixels <= slave_writedata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_status              = '0;
      w_status[ST_BUSY]     = ~w_idle;
      w_status[ST_DONE]     = r_done;
      w_status[ST_ERR]      = r_err;
      w_ctrl                = '0;
      w_ctrl[CTRL_IRQ_EN]   = r_irq_en;
   end

   always_ff @(posedge clk or negedge toplevel_reset) begin
      if (!toplevel_reset) begin
         r_readdata <= '0;
      end else if (w_rd) begin
         case (slave_address)
            A_CTRL:   r_readdata <= w_ctrl;
            A_STATUS: r_readdata <= w_status;
            A_A:      r_readdata <= r_a;
            A_B:      r_readdata <= r_b;
            A_BASE:   r_readdata <= r_base;
            A_PIXCNT: r_readdata <= w_pixel_count;
            A_FRAME:  r_readdata <= r_frame_pixels;
            A_CYCCNT: r_readdata <= r_cycle_count;
            default:  r_readdata <= '0;
         endcase
      end
   end

   assign slave_readdata = r_readdata;
   assign eng_rst_n      = r_eng_rst_n;
   assign eng_start      = r_eng_start;
   assign irq            = r_irq;
   assign eng_a          = r_a[CWIDTH-1:0];
   assign eng_b          = r_b[CWIDTH-1:0];

endmodule

// File: tb/tb_julia_csr_launcher.sv
// Directed bench for julia_csr_launcher: CSR access, frame launch/complete,
// IRQ, busy-start error, abort, address wrap, zero-length frame, async reset.
module tb_julia_csr_launcher;

   logic        clk = 1'b0;
   logic        toplevel_reset;
   logic [2:0]  slave_address;
   logic [31:0] slave_writedata;
   logic        slave_write, slave_read, slave_chipselect;
   logic [31:0] slave_readdata;
   logic [31:0] master_address, master_writedata;
   logic        master_write, master_waitrequest;
   logic        eng_rst_n, eng_start;
   logic [21:0] eng_a, eng_b;
   logic [31:0] eng_wr_addr, eng_wr_data;
   logic        eng_wr_enable, eng_wait_request, irq;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] rd;
   int rst_low, starts, tmo;

   always #5 clk = ~clk;

   julia_csr_launcher dut (
      .clk                (clk),
      .toplevel_reset     (toplevel_reset),
      .slave_address      (slave_address),
      .slave_writedata    (slave_writedata),
      .slave_write        (slave_write),
      .slave_read         (slave_read),
      .slave_chipselect   (slave_chipselect),
      .slave_readdata     (slave_readdata),
      .master_address     (master_address),
      .master_writedata   (master_writedata),
      .master_write       (master_write),
      .master_waitrequest (master_waitrequest),
      .eng_rst_n          (eng_rst_n),
      .eng_start          (eng_start),
      .eng_a              (eng_a),
      .eng_b              (eng_b),
      .eng_wr_addr        (eng_wr_addr),
      .eng_wr_data        (eng_wr_data),
      .eng_wr_enable      (eng_wr_enable),
      .eng_wait_request   (eng_wait_request),
      .irq                (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      slave_chipselect = 1'b1; slave_write = 1'b1; slave_address = a; slave_writedata = d;
      @(posedge clk); #1;
      slave_chipselect = 1'b0; slave_write = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = a;
      @(posedge clk); #1;
      d = slave_readdata;
      slave_chipselect = 1'b0; slave_read = 1'b0;
   endtask

   // Waits (bounded) for the RUN state, counting engine-reset cycles and start pulses.
   task automatic wait_run(output int n_low, output int n_start, output int timed_out);
      n_low = 0; n_start = 0; timed_out = 1;
      for (int i = 0; i < 30; i++) begin
         if (!eng_rst_n) n_low++;
         if (eng_start) n_start++;
         if (!eng_wait_request) begin
            timed_out = 0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic eng_write(input logic [31:0] a, input logic [31:0] d, input int stall);
      eng_wr_addr = a; eng_wr_data = d; eng_wr_enable = 1'b1;
      master_waitrequest = (stall > 0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
      end
      master_waitrequest = 1'b0;
      @(posedge clk); #1;
      eng_wr_enable = 1'b0;
   endtask

   initial begin
      toplevel_reset = 1'b0;
      slave_address = '0; slave_writedata = '0;
      slave_write = 1'b0; slave_read = 1'b0; slave_chipselect = 1'b0;
      master_waitrequest = 1'b0;
      eng_wr_addr = '0; eng_wr_data = '0; eng_wr_enable = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_readdata", slave_readdata, 32'h0);
      chk("rst_eng_rst_n", {31'b0, eng_rst_n}, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_eng_start", {31'b0, eng_start}, 32'h0);
      @(negedge clk);
      toplevel_reset = 1'b1;
      csr_read(3'd6, rd); chk("rst_frame_pixels", rd, 32'd307200);
      csr_read(3'd1, rd); chk("rst_status", rd, 32'h0);

      eng_wr_enable = 1'b1; #1;
      chk("idle_master_write", {31'b0, master_write}, 32'h0);
      chk("idle_eng_wait", {31'b0, eng_wait_request}, 32'h1);
      eng_wr_enable = 1'b0;

      // A/B registers and engine constant truncation
      csr_write(3'd2, 32'hFFFF_FFFF);
      csr_write(3'd3, 32'h0012_3456);
      chk("eng_a", {10'b0, eng_a}, 32'h003F_FFFF);
      chk("eng_b", {10'b0, eng_b}, 32'h0012_3456);
      csr_read(3'd2, rd); chk("a_readback", rd, 32'hFFFF_FFFF);

      // Frame of 4 with a 2-cycle stall on the second write
      csr_write(3'd4, 32'h0000_1000);
      csr_write(3'd6, 32'd4);
      csr_write(3'd0, 32'h1);
      wait_run(rst_low, starts, tmo);
      chk("f1_timeout", tmo, 0);
      chk("f1_rst_low_cycles", rst_low, 4);
      chk("f1_start_pulses", starts, 1);
      eng_wr_addr = 32'h0; eng_wr_data = 32'hA5A5_0001; eng_wr_enable = 1'b1; #1;
      chk("f1_master_write", {31'b0, master_write}, 32'h1);
      chk("f1_master_addr", master_address, 32'h0000_1000);
      chk("f1_master_data", master_writedata, 32'hA5A5_0001);
      eng_write(32'h0, 32'hA5A5_0001, 0);
      eng_write(32'h4, 32'hA5A5_0002, 2);
      eng_write(32'h8, 32'hA5A5_0003, 0);
      eng_write(32'hC, 32'hA5A5_0004, 0);
      csr_read(3'd5, rd); chk("f1_pixel_count", rd, 32'd4);
      csr_read(3'd1, rd); chk("f1_status", rd, 32'h2);

      // IRQ on completion, cleared by W1C of done
      csr_write(3'd1, 32'h2);
      csr_write(3'd0, 32'h5);
      wait_run(rst_low, starts, tmo);
      chk("f2_timeout", tmo, 0);
      for (int i = 0; i < 4; i++) eng_write(32'(i * 4), 32'(i), 0);
      chk("f2_irq_set", {31'b0, irq}, 32'h1);
      csr_write(3'd1, 32'h2);
      chk("f2_irq_clear", {31'b0, irq}, 32'h0);
      csr_read(3'd1, rd); chk("f2_status_clear", rd, 32'h0);

      // Start while busy, then abort at PIXEL_COUNT=2
      csr_write(3'd0, 32'h1);
      csr_write(3'd0, 32'h1);
      wait_run(rst_low, starts, tmo);
      chk("f3_timeout", tmo, 0);
      chk("f3_single_start", starts, 1);
      csr_read(3'd1, rd); chk("f3_busy_err", rd, 32'h5);
      eng_write(32'h0, 32'h11, 0);
      eng_write(32'h4, 32'h22, 0);
      csr_write(3'd0, 32'h2);
      chk("f3_abort_rst_low", {31'b0, eng_rst_n}, 32'h0);
      chk("f3_abort_idle", {31'b0, eng_wait_request}, 32'h1);
      @(posedge clk); #1;
      chk("f3_abort_rst_high", {31'b0, eng_rst_n}, 32'h1);
      csr_read(3'd1, rd); chk("f3_status", rd, 32'h4);
      csr_read(3'd5, rd); chk("f3_pixel_count", rd, 32'd2);

      // Master address offset and wrap
      csr_write(3'd4, 32'h0800_0000);
      eng_wr_addr = 32'h10; #1;
      chk("addr_offset", master_address, 32'h0800_0010);
      csr_write(3'd4, 32'hFFFF_FFF0);
      eng_wr_addr = 32'h20; #1;
      chk("addr_wrap", master_address, 32'h0000_0010);

      // Zero-length frame
      csr_write(3'd1, 32'h6);
      csr_write(3'd6, 32'h0);
      csr_write(3'd0, 32'h5);
      chk("f0_irq_next_cycle", {31'b0, irq}, 32'h1);
      wait_run(rst_low, starts, tmo);
      chk("f0_no_run", tmo, 1);
      chk("f0_no_start", starts, 0);
      chk("f0_no_eng_rst", rst_low, 0);
      csr_read(3'd1, rd); chk("f0_status", rd, 32'h2);

      // Asynchronous reset mid-frame
      csr_write(3'd1, 32'h2);
      csr_write(3'd6, 32'd4);
      csr_write(3'd0, 32'h1);
      wait_run(rst_low, starts, tmo);
      chk("f4_timeout", tmo, 0);
      eng_wr_enable = 1'b1; #1;
      chk("f4_master_write", {31'b0, master_write}, 32'h1);
      toplevel_reset = 1'b0; #1;
      chk("f4_rst_master_write", {31'b0, master_write}, 32'h0);
      chk("f4_rst_eng_rst_n", {31'b0, eng_rst_n}, 32'h0);
      eng_wr_enable = 1'b0;
      @(negedge clk);
      toplevel_reset = 1'b1;
      csr_read(3'd6, rd); chk("f4_frame_pixels", rd, 32'd307200);
      csr_read(3'd4, rd); chk("f4_base_addr", rd, 32'h0);
      csr_read(3'd1, rd); chk("f4_status", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
